// File: rtl/padring_bank_seq_pkg.sv
// Shared types and helpers for the per-IO-bank pad power sequencer.
// Contents:
//   bank_state_e  - per-bank sequencer state with fixed encodings
//   pad_attr_t    - pad attribute bundle passed from pinmux to padring
//   pad_en_t      - input/output enable pair decoded from a bank state
//   DefaultPadBank- default bank index used to build the pad-to-bank map
//   state_to_en() - maps a bank state to its pad input/output enables
package padring_seq_pkg;

    // Encodings are fixed so that the state register can be probed in silicon.
    typedef enum logic [2:0] {
        BankOff      = 3'b000,
        BankDebounce = 3'b011,
        BankSettle   = 3'b101,
        BankOn       = 3'b110,
        BankFault    = 3'b111
    } bank_state_e;

    typedef struct packed {
        logic       pull_en;
        logic       pull_up;
        logic [1:0] drive;
    } pad_attr_t;

    typedef struct packed {
        logic ie;
        logic oe_en;
    } pad_en_t;

    // Every pad is placed in bank 0 unless the integrator supplies a map.
    localparam logic [31:0] DefaultPadBank = '0;

    // Inputs may be enabled as soon as the supply is stable (Settle), while
    // outputs are only released once the bank is fully On.
    function automatic pad_en_t state_to_en(bank_state_e s);
        pad_en_t en;
        en.ie    = (s == BankSettle) || (s == BankOn);
        en.oe_en = (s == BankOn);
        return en;
    endfunction

endpackage

// File: rtl/padring_bank_seq_if.sv
// Pad-side bus between pinmux, the bank sequencer and the padring.
// Signals:
//   pad_out_i/pad_oe_i/pad_attr_i - ungated values from pinmux
//   pad_out_o/pad_oe_o/pad_ie_o/pad_attr_o - gated values towards the pads
// Modports:
//   master - pinmux side (drives the ungated values, observes the pads)
//   slave  - sequencer side (consumes the ungated values, drives the pads)
interface padring_bank_seq_if
    import padring_seq_pkg::*;
#(
    parameter int unsigned NPads = 16
) ();

    logic      [NPads-1:0] pad_out_i;
    logic      [NPads-1:0] pad_oe_i;
    pad_attr_t [NPads-1:0] pad_attr_i;
    logic      [NPads-1:0] pad_out_o;
    logic      [NPads-1:0] pad_oe_o;
    logic      [NPads-1:0] pad_ie_o;
    pad_attr_t [NPads-1:0] pad_attr_o;

    modport master (
        output pad_out_i, pad_oe_i, pad_attr_i,
        input  pad_out_o, pad_oe_o, pad_ie_o, pad_attr_o
    );

    modport slave (
        input  pad_out_i, pad_oe_i, pad_attr_i,
        output pad_out_o, pad_oe_o, pad_ie_o, pad_attr_o
    );

endinterface

// File: rtl/padring_bank_seq_fsm.sv
// One IO bank's power sequencer: debounces power-OK, then walks through
// Settle to On, and latches a sticky error if power drops after debounce.
// Ports:
//   clk_i, rst_i - clock and synchronous active-high reset
//   en_i         - request to power the bank
//   pok_i        - bank power-OK, synchronous to clk_i
//   state_o      - current bank state (registered)
//   err_o        - sticky power-loss fault, cleared on entering Off
module padring_bank_fsm
    import padring_seq_pkg::*;
#(
    parameter int unsigned DebounceCycles = 16,
    parameter int unsigned SettleCycles   = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        pok_i,
    output bank_state_e state_o,
    output logic        err_o
);

    localparam int unsigned MaxCycles = (DebounceCycles > SettleCycles) ? DebounceCycles
                                                                        : SettleCycles;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);
    localparam logic [CntW-1:0] CntMax  = '1;
    localparam logic [CntW-1:0] DebLast = CntW'(DebounceCycles - 1);
    localparam logic [CntW-1:0] SetLast = CntW'(SettleCycles - 1);

    bank_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic            err_q, err_d;

    // Next-state logic. Dropping the enable wins over everything, and the
    // error flag is cleared whenever the bank heads back to Off, so a
    // simultaneous enable and pok drop never leaves an error behind.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
        if (!en_i) begin
            state_d = BankOff;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                BankOff: begin
                    if (pok_i) begin
                        state_d = BankDebounce;
                        cnt_d   = '0;
                    end
                end
                BankDebounce: begin
                    if (!pok_i) begin
                        state_d = BankOff;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                    end else if (cnt_q == DebLast) begin
                        state_d = BankSettle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                BankSettle: begin
                    if (!pok_i) begin
                        state_d = BankFault;
                        cnt_d   = '0;
                        err_d   = 1'b1;
                    end else if (cnt_q == SetLast) begin
                        state_d = BankOn;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                BankOn: begin
                    if (!pok_i) begin
                        state_d = BankFault;
                        err_d   = 1'b1;
                    end
                end
                BankFault: begin
                    state_d = BankFault;
                end
                default: begin
                    state_d = BankOff;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            endcase
        end
    end

    // State, counter and error flag all live in this one register stage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= BankOff;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign state_o = state_q;
    assign err_o   = err_q;

endmodule

// File: rtl/padring_bank_seq.sv
// Per-IO-bank power sequencer and output gate between pinmux and padring.
// Each bank runs its own sequencer; every pad is gated by the state of the
// bank it belongs to and registered once before reaching the padring.
// Ports:
//   clk_i, rst_i   - clock and synchronous active-high reset
//   bank_en_i      - per-bank power-up request
//   pok_i          - per-bank power-OK
//   freeze_i       - hold pad out/oe/attr (input enables keep following)
//   pad_if         - pinmux/pad bus (slave side)
//   bank_ready_o   - bank is On
//   bank_err_o     - sticky per-bank power-loss fault
module padring_bank_seq
    import padring_seq_pkg::*;
#(
    parameter int unsigned NIoBanks       = 4,
    parameter int unsigned NPads          = 16,
    parameter logic [NPads-1:0][$clog2(NIoBanks):0] PadBank =
        {NPads{DefaultPadBank[$clog2(NIoBanks):0]}},
    parameter int unsigned DebounceCycles = 16,
    parameter int unsigned SettleCycles   = 8,
    parameter pad_attr_t   ResetAttr      = '0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NIoBanks-1:0] bank_en_i,
    input  logic [NIoBanks-1:0] pok_i,
    input  logic                freeze_i,
    padring_bank_seq_if.slave   pad_if,
    output logic [NIoBanks-1:0] bank_ready_o,
    output logic [NIoBanks-1:0] bank_err_o
);

    // The state table is padded to the full range of the bank index so any
    // pad index selects a defined entry; unused slots read as Off.
    localparam int unsigned BankIdxW = $clog2(NIoBanks) + 1;
    localparam int unsigned NSlots   = 2 ** BankIdxW;

    bank_state_e           state_slot [NSlots];
    logic     [NSlots-1:0] ready_slot;
    pad_en_t               pad_en [NPads];

    logic      [NPads-1:0] out_q, out_d;
    logic      [NPads-1:0] oe_q, oe_d;
    logic      [NPads-1:0] ie_q, ie_d;
    pad_attr_t [NPads-1:0] attr_q, attr_d;

    for (genvar b = 0; b < NIoBanks; b++) begin : g_bank
        padring_bank_fsm #(
            .DebounceCycles (DebounceCycles),
            .SettleCycles   (SettleCycles)
        ) u_fsm (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .en_i    (bank_en_i[b]),
            .pok_i   (pok_i[b]),
            .state_o (state_slot[b]),
            .err_o   (bank_err_o[b])
        );
    end

    for (genvar b = NIoBanks; b < NSlots; b++) begin : g_unused_slot
        assign state_slot[b] = BankOff;
    end

    for (genvar b = 0; b < NSlots; b++) begin : g_ready
        assign ready_slot[b] = (state_slot[b] == BankOn);
    end

    assign bank_ready_o = ready_slot[NIoBanks-1:0];

    for (genvar k = 0; k < NPads; k++) begin : g_pad
        assign pad_en[k] = state_to_en(state_slot[PadBank[k]]);

        a_bank_range: assert property (@(posedge clk_i) 32'(PadBank[k]) < NIoBanks);

        a_oe_ready: assert property (@(posedge clk_i) disable iff (rst_i)
            (oe_q[k] && !$past(freeze_i)) |-> $past(ready_slot[PadBank[k]]));
    end

    // Pad gating. A bank that is not On always drives the safe values, even
    // while frozen, so a power loss can never leave a pad driving. Freeze only
    // holds pads whose bank is still On; input enables are never frozen.
    always_comb begin
        out_d  = out_q;
        oe_d   = oe_q;
        attr_d = attr_q;
        ie_d   = '0;
        for (int k = 0; k < NPads; k++) begin
            ie_d[k] = pad_en[k].ie;
            if (!pad_en[k].oe_en) begin
                out_d[k]  = 1'b0;
                oe_d[k]   = 1'b0;
                attr_d[k] = ResetAttr;
            end else if (!freeze_i) begin
                out_d[k]  = pad_if.pad_out_i[k];
                oe_d[k]   = pad_if.pad_oe_i[k];
                attr_d[k] = pad_if.pad_attr_i[k];
            end
        end
    end

    // Output registers give every pad signal exactly one cycle of latency.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q  <= '0;
            oe_q   <= '0;
            ie_q   <= '0;
            attr_q <= {NPads{ResetAttr}};
        end else begin
            out_q  <= out_d;
            oe_q   <= oe_d;
            ie_q   <= ie_d;
            attr_q <= attr_d;
        end
    end

    assign pad_if.pad_out_o  = out_q;
    assign pad_if.pad_oe_o   = oe_q;
    assign pad_if.pad_ie_o   = ie_q;
    assign pad_if.pad_attr_o = attr_q;

endmodule

// File: tb/tb_padring_bank_seq.sv
// Self-checking bench for padring_bank_seq with DebounceCycles=4 and
// SettleCycles=2. Pads 0-3 belong to bank 0, 4-7 to bank 1, 8-11 to bank 2
// and 12-15 to bank 3. Bank 1 is requested but never gets power-OK and bank 2
// has power-OK but no request, so both must keep their pads quiet throughout.
module tb_padring_bank_seq;
    import padring_seq_pkg::*;

    localparam pad_attr_t AttrR = 4'b0101;
    localparam pad_attr_t AttrA = 4'b1010;
    localparam pad_attr_t AttrB = 4'b0111;
    localparam logic [15:0][2:0] TbPadBank = {{4{3'd3}}, {4{3'd2}}, {4{3'd1}}, {4{3'd0}}};

    typedef struct {
        logic       rst;
        logic [3:0] en;
        logic [3:0] pok;
        logic       frz;
        logic [15:0] out;
        logic [15:0] oe;
        pad_attr_t  attr;
    } stim_t;

    typedef struct {
        string      name;
        logic [3:0] ready;
        logic [3:0] err;
        logic [15:0] ie;
        logic [15:0] oe;
        logic [15:0] out;
        pad_attr_t  attr0;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [3:0] bankEn;
    logic [3:0] pok;
    logic       freeze;
    logic [3:0] bankReady;
    logic [3:0] bankErr;

    int checks = 0;
    int errors = 0;
    exp_t expQ[$];
    vec_t tbl[10];

    padring_bank_seq_if #(.NPads(16)) padIf ();

    padring_bank_seq #(
        .NIoBanks       (4),
        .NPads          (16),
        .PadBank        (TbPadBank),
        .DebounceCycles (4),
        .SettleCycles   (2),
        .ResetAttr      (AttrR)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .bank_en_i    (bankEn),
        .pok_i        (pok),
        .freeze_i     (freeze),
        .pad_if       (padIf),
        .bank_ready_o (bankReady),
        .bank_err_o   (bankErr)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired before the test finished");
        $fatal(1, "[TB] watchdog");
    end

    function automatic stim_t mkStim(logic r, logic [3:0] en, logic [3:0] pk, logic frz,
                                     logic [15:0] out, logic [15:0] oe, pad_attr_t attr);
        stim_t s;
        s.rst = r; s.en = en; s.pok = pk; s.frz = frz;
        s.out = out; s.oe = oe; s.attr = attr;
        return s;
    endfunction

    function automatic exp_t mkExp(string name, logic [3:0] ready, logic [3:0] err,
                                   logic [15:0] ie, logic [15:0] oe, logic [15:0] out,
                                   pad_attr_t attr0);
        exp_t e;
        e.name = name; e.ready = ready; e.err = err;
        e.ie = ie; e.oe = oe; e.out = out; e.attr0 = attr0;
        return e;
    endfunction

    task automatic cmp(string name, string field, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s.%s actual=%h required=%h", name, field, act, req);
        end
    endtask

    // Drive one cycle of inputs, queue its expectation and take the edge.
    task automatic applyStimulus(stim_t s, exp_t e);
        rst    = s.rst;
        bankEn = s.en;
        pok    = s.pok;
        freeze = s.frz;
        padIf.pad_out_i  = s.out;
        padIf.pad_oe_i   = s.oe;
        padIf.pad_attr_i = {16{s.attr}};
        expQ.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Pop the oldest expectation and compare it with what the DUT now shows.
    task automatic checkOutput();
        exp_t e;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard empty actual=0 required=1");
            return;
        end
        e = expQ.pop_front();
        cmp(e.name, "ready", 32'(bankReady), 32'(e.ready));
        cmp(e.name, "err",   32'(bankErr),   32'(e.err));
        cmp(e.name, "ie",    32'(padIf.pad_ie_o),  32'(e.ie));
        cmp(e.name, "oe",    32'(padIf.pad_oe_o),  32'(e.oe));
        cmp(e.name, "out",   32'(padIf.pad_out_o), 32'(e.out));
        cmp(e.name, "attr0", 32'(padIf.pad_attr_o[0]), 32'(e.attr0));
        cmp(e.name, "attr4", 32'(padIf.pad_attr_o[4]), 32'(AttrR));
    endtask

    task automatic step(stim_t s, exp_t e);
        applyStimulus(s, e);
        checkOutput();
    endtask

    initial begin
        // Power-up of bank 0 from reset; row i>=1 is edge i-1 of the sequence.
        tbl[0] = '{mkStim(1, 4'b0000, 4'b0000, 0, 16'h5555, 16'hFFFF, AttrA),
                   mkExp("reset", 4'h0, 4'h0, 16'h0, 16'h0, 16'h0, AttrR)};
        for (int i = 1; i < 10; i++) begin
            tbl[i].s = mkStim(0, 4'b0011, 4'b0101, 0, 16'h5555, 16'hFFFF, AttrA);
            tbl[i].e = mkExp($sformatf("pwrup_e%0d", i - 1), 4'h0, 4'h0, 16'h0, 16'h0, 16'h0, AttrR);
        end
        tbl[6].e.ie = 16'h000F;
        tbl[7].e.ie = 16'h000F; tbl[7].e.ready = 4'h1;
        for (int i = 8; i < 10; i++) begin
            tbl[i].e = mkExp($sformatf("pwrup_e%0d", i - 1), 4'h1, 4'h0,
                             16'h000F, 16'h000F, 16'h0005, AttrA);
        end

        for (int i = 0; i < 10; i++) step(tbl[i].s, tbl[i].e);

        // Freeze while On: new out/attr must not reach the pads until release.
        step(mkStim(0, 4'b0011, 4'b0101, 1, 16'hFFFF, 16'hFFFF, AttrB),
             mkExp("frz1", 4'h1, 4'h0, 16'h000F, 16'h000F, 16'h0005, AttrA));
        step(mkStim(0, 4'b0011, 4'b0101, 1, 16'hFFFF, 16'hFFFF, AttrB),
             mkExp("frz2", 4'h1, 4'h0, 16'h000F, 16'h000F, 16'h0005, AttrA));
        step(mkStim(0, 4'b0011, 4'b0101, 0, 16'hFFFF, 16'hFFFF, AttrB),
             mkExp("unfrz", 4'h1, 4'h0, 16'h000F, 16'h000F, 16'h000F, AttrB));

        // Power loss while frozen: Fault next edge, pads forced safe one later.
        step(mkStim(0, 4'b0011, 4'b0100, 1, 16'hFFFF, 16'hFFFF, AttrB),
             mkExp("pokdrop1", 4'h0, 4'h1, 16'h000F, 16'h000F, 16'h000F, AttrB));
        step(mkStim(0, 4'b0011, 4'b0100, 1, 16'hFFFF, 16'hFFFF, AttrB),
             mkExp("pokdrop2", 4'h0, 4'h1, 16'h0, 16'h0, 16'h0, AttrR));
        step(mkStim(0, 4'b0010, 4'b0100, 0, 16'hFFFF, 16'hFFFF, AttrB),
             mkExp("faultclr", 4'h0, 4'h0, 16'h0, 16'h0, 16'h0, AttrR));
        step(mkStim(0, 4'b0010, 4'b0101, 0, 16'hFFFF, 16'hFFFF, AttrB),
             mkExp("offnoen", 4'h0, 4'h0, 16'h0, 16'h0, 16'h0, AttrR));

        // One-cycle pok glitch on edge 2 of Debounce restarts the whole count.
        for (int g = 0; g <= 10; g++) begin
            step(mkStim(0, 4'b0011, (g == 2) ? 4'b0100 : 4'b0101, 0, 16'hFFFF, 16'hFFFF, AttrB),
                 mkExp($sformatf("glitch_e%0d", g),
                       (g >= 9) ? 4'h1 : 4'h0, 4'h0,
                       (g >= 8) ? 16'h000F : 16'h0000,
                       (g >= 10) ? 16'h000F : 16'h0000,
                       (g >= 10) ? 16'h000F : 16'h0000,
                       (g >= 10) ? AttrB : AttrR));
        end

        // Enable and pok drop together: straight to Off, no error recorded.
        step(mkStim(0, 4'b0010, 4'b0100, 0, 16'hFFFF, 16'hFFFF, AttrB),
             mkExp("bothdrop1", 4'h0, 4'h0, 16'h000F, 16'h000F, 16'h000F, AttrB));
        step(mkStim(0, 4'b0010, 4'b0100, 0, 16'hFFFF, 16'hFFFF, AttrB),
             mkExp("bothdrop2", 4'h0, 4'h0, 16'h0, 16'h0, 16'h0, AttrR));

        // Reset while in Settle, then a full-length re-sequence.
        for (int h = 0; h <= 5; h++) begin
            step(mkStim((h == 5), 4'b0011, 4'b0101, 0, 16'hFFFF, 16'hFFFF, AttrB),
                 mkExp($sformatf("rstsettle_e%0d", h), 4'h0, 4'h0, 16'h0, 16'h0, 16'h0, AttrR));
        end
        for (int k = 0; k <= 6; k++) begin
            step(mkStim(0, 4'b0011, 4'b0101, 0, 16'hFFFF, 16'hFFFF, AttrB),
                 mkExp($sformatf("reseq_e%0d", k),
                       (k >= 6) ? 4'h1 : 4'h0, 4'h0,
                       (k >= 5) ? 16'h000F : 16'h0000,
                       16'h0, 16'h0, AttrR));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
